// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: the command and trace-RAM signal bundle of the capture sequencer.
//
// Parameters
//   AW          trace RAM address width
//
// Command side (driven by the command layer / sample path)
//   arm         one-cycle pulse: start a new capture
//   abort       one-cycle pulse: stop the capture and return to idle
//   smpl_en     one strobe per decimated sample
//   trig        trigger event pulse from the trigger detector
//   trig_pos    post-trigger sample count, latched on arm
//   clr_done    pulse after the dump of a frozen buffer has finished
//
// RAM / status side (driven by capture_ctrl)
//   we          capture owns the RAM
//   cap_en      RAM write enable for this cycle
//   cap_addr    RAM write address
//   trace_end   address of the last post-trigger write
//   armed       trigger is accepted from now on
//   triggered   trigger seen, post-fill in progress
//   capture_done buffer frozen and valid
//
// Modports: master is the command/RAM side, slave is capture_ctrl.
interface capture_ctrl_if #(
   parameter int unsigned AW = 9
);
   logic          arm;
   logic          abort;
   logic          smpl_en;
   logic          trig;
   logic [AW-1:0] trig_pos;
   logic          clr_done;

   logic          we;
   logic          cap_en;
   logic [AW-1:0] cap_addr;
   logic [AW-1:0] trace_end;
   logic          armed;
   logic          triggered;
   logic          capture_done;

   modport master (
      output arm, abort, smpl_en, trig, trig_pos, clr_done,
      input  we, cap_en, cap_addr, trace_end, armed, triggered, capture_done
   );

   modport slave (
      input  arm, abort, smpl_en, trig, trig_pos, clr_done,
      output we, cap_en, cap_addr, trace_end, armed, triggered, capture_done
   );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: acquisition sequencer for the 3-channel trace RAM.
//
// Runs a circular write pointer gated by the sample strobe, enforces a pre-trigger fill so the
// whole buffer holds valid data, counts post-trigger samples and then freezes the buffer,
// publishing the address of the last write as trace_end. The oldest sample of a frozen trace
// sits at trace_end + 1 (mod DEPTH).
//
// Parameters
//   DEPTH       trace RAM entries per channel (power of 2, at least 4)
//   AW          address width, $clog2(DEPTH)
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   bus         capture_ctrl_if slave modport (command inputs, RAM control and status outputs)
module capture_ctrl #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           rst,
   capture_ctrl_if.slave bus
);

   // Pre-fill counter needs one extra bit so it can saturate at DEPTH itself.
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StPreFill,
      StArmed,
      StPost,
      StDone
   } state_e;

   state_e        state_q;
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] tp_q;
   logic [AW-1:0] post_cnt_q;
   logic [AW-1:0] trace_end_q;
   logic [CW-1:0] pre_cnt_q;
   logic          we_q;
   logic          armed_q;
   logic          triggered_q;
   logic          done_q;

   logic          wr;
   logic [AW-1:0] wptr_inc;
   logic [CW-1:0] pre_cnt_inc;
   logic [CW-1:0] pre_goal;
   logic [AW-1:0] tp_arm;
   logic          last_post;

   always_comb begin
      // we_q is high exactly in PRE_FILL/ARMED/POST, so it doubles as the write gate.
      wr          = bus.smpl_en & we_q;
      // DEPTH is a power of two: the natural AW-bit wrap is the circular wrap.
      wptr_inc    = wptr_q + 1'b1;
      pre_cnt_inc = (pre_cnt_q == DepthC) ? pre_cnt_q : pre_cnt_q + 1'b1;
      // Pre-trigger writes needed so that pre + post writes cover the whole buffer.
      pre_goal    = DepthC - {1'b0, tp_q};
      // A post-trigger count of zero still captures the sample after the trigger.
      tp_arm      = (bus.trig_pos == '0) ? AW'(1) : bus.trig_pos;
      last_post   = (post_cnt_q == tp_q - 1'b1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         wptr_q      <= '0;
         tp_q        <= '0;
         post_cnt_q  <= '0;
         trace_end_q <= '0;
         pre_cnt_q   <= '0;
         we_q        <= 1'b0;
         armed_q     <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else if (bus.abort) begin
         // trace_end deliberately held: only a completed capture may move it.
         state_q     <= StIdle;
         we_q        <= 1'b0;
         armed_q     <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else if (bus.arm) begin
         // Arm restarts from any state and outranks a coincident trigger.
         state_q     <= StPreFill;
         tp_q        <= tp_arm;
         wptr_q      <= '0;
         pre_cnt_q   <= '0;
         post_cnt_q  <= '0;
         we_q        <= 1'b1;
         armed_q     <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         if (wr) begin
            wptr_q    <= wptr_inc;
            pre_cnt_q <= pre_cnt_inc;
         end
         case (state_q)
            StIdle: begin
            end
            StPreFill: begin
               // Triggers are ignored until the pre-trigger portion is filled.
               if (wr && (pre_cnt_inc >= pre_goal)) begin
                  state_q <= StArmed;
                  armed_q <= 1'b1;
               end
            end
            StArmed: begin
               // A write in the trigger cycle is still a pre-trigger sample.
               if (bus.trig) begin
                  state_q     <= StPost;
                  post_cnt_q  <= '0;
                  armed_q     <= 1'b0;
                  triggered_q <= 1'b1;
               end
            end
            StPost: begin
               if (wr) begin
                  if (last_post) begin
                     trace_end_q <= wptr_q;
                     done_q      <= 1'b1;
                     state_q     <= StDone;
                     we_q        <= 1'b0;
                     triggered_q <= 1'b0;
                  end else begin
                     post_cnt_q <= post_cnt_q + 1'b1;
                  end
               end
            end
            StDone: begin
               if (bus.clr_done) begin
                  state_q <= StIdle;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= StIdle;
               we_q        <= 1'b0;
               armed_q     <= 1'b0;
               triggered_q <= 1'b0;
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.we           = we_q;
   assign bus.cap_en       = wr;
   assign bus.cap_addr     = wptr_q;
   assign bus.trace_end    = trace_end_q;
   assign bus.armed        = armed_q;
   assign bus.triggered    = triggered_q;
   assign bus.capture_done = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: self-checking bench for capture_ctrl at DEPTH=512.
// A cycle model predicts status outputs and pushes expected write addresses to a queue that is
// popped whenever the DUT writes; a vector table adds hand-derived end-of-capture results, and
// short directed sequences cover abort, restart, async reset, clr_done and arm/trig collision.
module tb_capture_ctrl;

   localparam int unsigned DEPTH = 512;
   localparam int unsigned AW    = 9;

   localparam int M_IDLE  = 0;
   localparam int M_PRE   = 1;
   localparam int M_ARMED = 2;
   localparam int M_POST  = 3;
   localparam int M_DONE  = 4;

   logic clk;
   logic rst;

   capture_ctrl_if #(.AW(AW)) bus ();

   capture_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Bench model state
   int m_state;
   int m_wptr;
   int m_pre;
   int m_post;
   int m_tp;
   int m_trace;
   int m_done;
   int unsigned exp_q[$];

   // Values sampled in the last cycle
   logic          s_we;
   logic          s_cap_en;
   logic [AW-1:0] s_cap_addr;
   logic [AW-1:0] s_trace;
   logic          s_armed;
   logic          s_trig;
   logic          s_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit capturing(input int st);
      return (st == M_PRE) || (st == M_ARMED) || (st == M_POST);
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_wptr  = 0;
      m_pre   = 0;
      m_post  = 0;
      m_tp    = 0;
      m_trace = 0;
      m_done  = 0;
      exp_q.delete();
   endtask

   // Called just after a rising edge; drives one cycle of inputs, checks mid-cycle, advances.
   task automatic run_cycle(input logic a, input logic ab, input logic s, input logic t,
                            input logic [AW-1:0] tpos, input logic c);
      bit exp_en;
      bit wr;
      bus.arm      = a;
      bus.abort    = ab;
      bus.smpl_en  = s;
      bus.trig     = t;
      bus.trig_pos = tpos;
      bus.clr_done = c;
      exp_en = s && capturing(m_state);
      if (exp_en) exp_q.push_back(m_wptr);
      @(negedge clk);
      s_we       = bus.we;
      s_cap_en   = bus.cap_en;
      s_cap_addr = bus.cap_addr;
      s_trace    = bus.trace_end;
      s_armed    = bus.armed;
      s_trig     = bus.triggered;
      s_done     = bus.capture_done;
      check("we", s_we, capturing(m_state));
      check("armed", s_armed, m_state == M_ARMED);
      check("triggered", s_trig, m_state == M_POST);
      check("capture_done", s_done, m_done);
      check("trace_end", s_trace, m_trace);
      check("cap_en", s_cap_en, exp_en);
      if (s_cap_en && exp_q.size() != 0) check("cap_addr", s_cap_addr, exp_q.pop_front());
      exp_q.delete();
      @(posedge clk);
      wr = exp_en;
      if (ab) begin
         m_state = M_IDLE;
         m_done  = 0;
      end else if (a) begin
         m_state = M_PRE;
         m_tp    = (tpos == 0) ? 1 : int'(tpos);
         m_wptr  = 0;
         m_pre   = 0;
         m_done  = 0;
      end else begin
         case (m_state)
            M_PRE: if (wr) begin
               m_pre = (m_pre + 1 > DEPTH) ? DEPTH : m_pre + 1;
               if (m_pre >= DEPTH - m_tp) m_state = M_ARMED;
            end
            M_ARMED: if (t) begin
               m_state = M_POST;
               m_post  = 0;
            end
            M_POST: if (wr) begin
               if (m_post == m_tp - 1) begin
                  m_trace = m_wptr;
                  m_done  = 1;
                  m_state = M_DONE;
               end else begin
                  m_post++;
               end
            end
            M_DONE: if (c) begin
               m_state = M_IDLE;
               m_done  = 0;
            end
            default: ;
         endcase
         if (wr) m_wptr = (m_wptr + 1) % DEPTH;
      end
      #1;
   endtask

   // Strobe every cycle until armed (want_done=0) or capture_done (want_done=1).
   task automatic strobe_until(input bit want_done, input int budget);
      int n;
      n = 0;
      while (!(want_done ? s_done : s_armed) && n < budget) begin
         run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
         n++;
      end
      check(want_done ? "reach done" : "reach armed", want_done ? s_done : s_armed, 1);
   endtask

   typedef struct {
      int tp;
      int period;
      int early_trig;
      int trig_write;
      int exp_armed_at;
      int exp_posts;
      int exp_trace_end;
   } vec_t;

   vec_t vecs[5];

   int  writes, first_armed, posts, cyc, last_post;
   bit  fin;
   logic s, t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_reset();
      s_armed = 1'b0;
      s_done  = 1'b0;

      //         tp   per early trigw armed posts tend
      vecs[0] = '{12,  1,  0,  600, 500,  12,  99};
      vecs[1] = '{100, 1,  200, 450, 412, 100, 37};
      vecs[2] = '{0,   1,  0,  600, 511,  1,   88};
      vecs[3] = '{5,   4,  0,  520, 507,  5,   12};
      vecs[4] = '{511, 1,  0,  3,   1,    511, 1};

      rst          = 1'b1;
      bus.arm      = 1'b0;
      bus.abort    = 1'b0;
      bus.smpl_en  = 1'b0;
      bus.trig     = 1'b0;
      bus.trig_pos = '0;
      bus.clr_done = 1'b0;
      #3;
      check("reset we", bus.we, 0);
      check("reset cap_addr", bus.cap_addr, 0);
      check("reset trace_end", bus.trace_end, 0);
      check("reset capture_done", bus.capture_done, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         writes      = 0;
         first_armed = -1;
         posts       = 0;
         cyc         = 0;
         last_post   = -100;
         fin         = 1'b0;
         run_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
         run_cycle(1'b1, 1'b0, 1'b0, 1'b0, AW'(vecs[i].tp), 1'b0);
         while (!fin && cyc < 5000) begin
            s = ((cyc % vecs[i].period) == 0);
            t = s && ((writes + 1 == vecs[i].trig_write) || (writes + 1 == vecs[i].early_trig));
            run_cycle(1'b0, 1'b0, s, t, '0, 1'b0);
            if (s_armed && first_armed < 0) first_armed = writes;
            if (s_trig && s_cap_en) begin
               posts++;
               last_post = cyc;
            end
            if (s_done) begin
               fin = 1'b1;
               check("done latency", cyc - last_post, 1);
               check("we after done", s_we, 0);
            end
            writes += int'(s);
            cyc++;
         end
         check("vec finished", fin, 1);
         check("vec armed at write", first_armed, vecs[i].exp_armed_at);
         check("vec post writes", posts, vecs[i].exp_posts);
         check("vec trace_end", s_trace, vecs[i].exp_trace_end);
      end

      // Abort in POST: trace_end from the last vector (1) must survive.
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, AW'(3), 1'b0);
      strobe_until(1'b0, 1000);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("post triggered", s_trig, 1);
      run_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      check("abort we", s_we, 0);
      check("abort capture_done", s_done, 0);
      check("abort trace_end", s_trace, 1);
      check("abort triggered", s_trig, 0);

      // Arm in POST restarts from address 0 with a cleared pre-fill count.
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, AW'(3), 1'b0);
      strobe_until(1'b0, 1000);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      run_cycle(1'b1, 1'b0, 1'b1, 1'b0, AW'(3), 1'b0);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("restart cap_addr", s_cap_addr, 0);
      check("restart we", s_we, 1);
      check("restart triggered", s_trig, 0);
      for (int k = 0; k < 100; k++) run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("restart not armed early", s_armed, 0);

      // Asynchronous reset in POST clears every output without a clock edge.
      strobe_until(1'b0, 1000);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      bus.smpl_en = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("async rst we", bus.we, 0);
      check("async rst cap_en", bus.cap_en, 0);
      check("async rst cap_addr", bus.cap_addr, 0);
      check("async rst trace_end", bus.trace_end, 0);
      check("async rst armed", bus.armed, 0);
      check("async rst triggered", bus.triggered, 0);
      check("async rst capture_done", bus.capture_done, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // DONE then clr_done returns to IDLE.
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, AW'(511), 1'b0);
      strobe_until(1'b0, 100);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
      strobe_until(1'b1, 1000);
      check("done trace_end", s_trace, 1);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      check("clr capture_done", s_done, 0);
      check("clr we", s_we, 0);

      // Arm and trig together from DONE: arm wins, trigger dropped.
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, AW'(511), 1'b0);
      strobe_until(1'b0, 100);
      run_cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
      strobe_until(1'b1, 1000);
      run_cycle(1'b1, 1'b0, 1'b1, 1'b1, AW'(200), 1'b0);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      check("arm+trig we", s_we, 1);
      check("arm+trig triggered", s_trig, 0);
      check("arm+trig armed", s_armed, 0);
      check("arm+trig capture_done", s_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequences acquisition into the 3-channel trace RAM.
- Runs a circular write pointer, gates writes with the sample-rate strobe, and enforces the pre-trigger fill.
- Counts post-trigger samples, then freezes the buffer and publishes trace_end.
- Drives we, cap_en, cap_addr and trace_end of the RAM interface. While we is low the RAM interface owns the RAM for dumping from trace_end+1.

Parameters:
DEPTH, 512, trace RAM entries per channel (power of 2, at least 4)
AW, $clog2(DEPTH), address width (9 at default)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
arm  in  1  one-cycle pulse from command layer: start a new capture
abort  in  1  one-cycle pulse: stop capture and return to IDLE
smpl_en  in  1  one-cycle strobe per decimated sample (ADC data valid this cycle)
trig  in  1  trigger event pulse from trigger detector
trig_pos  in  AW  post-trigger sample count; latched on arm
clr_done  in  1  pulse from command layer after dump complete
we  out  1  capture owns the RAM (high in PRE_FILL/ARMED/POST)
cap_en  out  1  RAM write enable for this cycle
cap_addr  out  AW  RAM write address
trace_end  out  AW  address of last post-trigger write
armed  out  1  status: trigger accepted from now on
triggered  out  1  status: trigger seen, post-fill in progress
capture_done  out  1  status: buffer frozen and valid

Behaviour:
- Reset (async, rst=1): state=IDLE, we=0, cap_en=0, cap_addr=0, trace_end=0, armed=0, triggered=0, capture_done=0, all counters 0. Reset mid-capture discards the capture; no partial trace_end update.
- State machine IDLE, PRE_FILL, ARMED, POST, DONE:
  - IDLE: arm -> PRE_FILL.
  - PRE_FILL: trig is ignored. After the write that makes pre_cnt >= DEPTH - tp -> ARMED.
  - ARMED: trig -> POST, post_cnt=0.
  - POST: write with post_cnt == tp-1 -> DONE.
  - DONE: clr_done -> IDLE.
- On arm: tp latched from trig_pos, with trig_pos=0 treated as tp=1. Also wptr=0, pre_cnt=0, capture_done=0.
- Write datapath:
  - cap_en = smpl_en AND state in {PRE_FILL, ARMED, POST}; combinational, same cycle as smpl_en.
  - cap_addr = wptr register.
  - Each write advances wptr by 1, wrapping DEPTH-1 -> 0.
  - The RAM interface registers en/addr, so there is one cycle of latency to the RAM.
- pre_cnt counts writes from arm and saturates at DEPTH. post_cnt counts writes in POST.
- Trigger and write in the same ARMED cycle: the write is a pre-trigger sample; the state moves to POST and the next write is post sample 0.
- On the last POST write: trace_end <= cap_addr, capture_done=1 and stays high. The oldest sample is then at trace_end+1 mod DEPTH.
- Total writes per capture are at least DEPTH, so the buffer is always fully valid.
- we: high in PRE_FILL/ARMED/POST, low in IDLE/DONE. It is registered and updates on the state-change clock edge.
- armed=1 in ARMED only. triggered=1 in POST only.
- Priority, highest first: rst, abort, arm, trig/clr_done.
  - abort in any state -> IDLE, capture_done=0, trace_end held.
  - arm while capturing or in DONE restarts the capture.
  - arm and trig in the same cycle: arm wins and trig is dropped.
- trace_end changes only on capture completion.
- Dump is legal only when capture_done=1; the command layer gates this.

Test Plan:
- DEPTH=512, arm, trig_pos=12, smpl_en every cycle, trig pulsed at write #600 -> trigger accepted.
  - Exactly 12 further writes (cap_addr 88..99).
  - trace_end=99, capture_done=1, we=0 the cycle after the last write.
- arm, trig_pos=100, trig pulsed at write #200 (before 412 pre writes) -> trig ignored, armed=0.
  - armed rises after write #412.
  - A trig at write #450 yields trace_end = 549 mod 512 = 37.
- smpl_en every 4th cycle with trig coincident with smpl_en in ARMED -> that write counts as pre-trigger; post_cnt starts at the next strobe; cap_en never high without smpl_en.
- Wrap check: cap_addr sequence ...510, 511, 0, 1 with no glitch; trig_pos=0 behaves as 1 -> exactly one post write.
- In POST, abort -> IDLE next cycle, we=0, capture_done=0, trace_end unchanged.
- In POST, arm -> restart: cap_addr=0, pre_cnt=0.
- In POST, rst asserted asynchronously -> all outputs 0 immediately.
- DONE then clr_done -> IDLE, capture_done=0.
- arm and trig in the same cycle from DONE -> PRE_FILL, triggered stays 0.
